// File: rtl/axis_pkt_checker.sv
// AXI-Stream packet checker: verifies an incrementing data pattern and packet length,
// counts packets/errors. Optional LFSR backpressure is built when AXIS_CHK_BACKPRESSURE_EN is defined.
module axis_pkt_checker #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic [LEN_WIDTH-1:0]  exp_len_i,
  input  logic [DATA_WIDTH-1:0] start_val_i,
  input  logic                  bp_en_i,
  input  logic                  clr_i,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic [2:0]            err_flags_o,
  output logic                  err_o,
  output logic                  busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  beat_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  bad_q;
  logic                  long_q;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q;
  logic [CNT_WIDTH-1:0]  err_cnt_q;
  logic [2:0]            err_flags_q;
  logic                  err_q;
  logic                  tready_q;

  logic                  xfer;
  logic                  first_beat;
  logic [LEN_WIDTH-1:0]  cur_len;
  logic [LEN_WIDTH-1:0]  last_idx;
  logic [LEN_WIDTH-1:0]  beat_idx;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  len_chk;
  logic                  at_last_idx;
  logic                  data_err;
  logic                  short_err;
  logic                  long_err;
  logic                  pkt_done;
  logic                  pkt_bad;

  assign xfer       = s_axis_tvalid & tready_q;
  assign first_beat = (state_q == IDLE);

  // Beat 0 uses the live config; later beats use the values latched on beat 0.
  assign cur_len  = first_beat ? exp_len_i   : len_q;
  assign exp_data = first_beat ? start_val_i : data_q;
  assign beat_idx = first_beat ? '0          : beat_q;

  assign len_chk     = (cur_len != '0);
  assign last_idx    = cur_len - LEN_WIDTH'(1);
  assign at_last_idx = len_chk && (beat_idx == last_idx);

  // Data compare is suppressed from the overrun beat onward until tlast.
  assign data_err  = xfer && !long_q && !(at_last_idx && !s_axis_tlast)
                     && (s_axis_tdata != exp_data);
  assign short_err = xfer && s_axis_tlast && len_chk && (beat_idx < last_idx);
  assign long_err  = xfer && !s_axis_tlast && at_last_idx && !long_q;

  assign pkt_done = xfer && s_axis_tlast;
  assign pkt_bad  = bad_q | data_err | short_err | long_err;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer && !s_axis_tlast) begin
          state_d = DATA;
        end
      end
      DATA: begin
        busy_o = 1'b1;
        if (xfer && s_axis_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      beat_q <= '0;
      len_q  <= '0;
      data_q <= '0;
      bad_q  <= 1'b0;
      long_q <= 1'b0;
    end else if (xfer) begin
      if (s_axis_tlast) begin
        beat_q <= '0;
        bad_q  <= 1'b0;
        long_q <= 1'b0;
      end else begin
        beat_q <= (beat_idx == '1) ? beat_idx : beat_idx + LEN_WIDTH'(1);
        data_q <= exp_data + DATA_WIDTH'(1);
        bad_q  <= pkt_bad;
        long_q <= long_q | long_err;
        if (first_beat) begin
          len_q <= exp_len_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
      err_flags_q <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= pkt_done && pkt_bad;
      if (clr_i) begin
        pkt_cnt_q   <= '0;
        err_cnt_q   <= '0;
        err_flags_q <= '0;
      end else begin
        err_flags_q <= err_flags_q | {long_err, short_err, data_err};
        if (pkt_done) begin
          if (pkt_cnt_q != '1) begin
            pkt_cnt_q <= pkt_cnt_q + CNT_WIDTH'(1);
          end
          if (pkt_bad && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

`ifdef AXIS_CHK_BACKPRESSURE_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      lfsr_q   <= LFSR_SEED;
      tready_q <= 1'b0;
    end else begin
      lfsr_q   <= {lfsr_q[14:0], lfsr_fb};
      tready_q <= ~bp_en_i | (lfsr_q[1:0] != 2'b00);
    end
  end
`else
  logic unused_bp;
  assign unused_bp = bp_en_i ^ (^LFSR_SEED);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      tready_q <= 1'b0;
    end else begin
      tready_q <= 1'b1;
    end
  end
`endif

  assign s_axis_tready = tready_q;
  assign pkt_cnt_o     = pkt_cnt_q;
  assign err_cnt_o     = err_cnt_q;
  assign err_flags_o   = err_flags_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_axis_pkt_checker.sv
// Scoreboard bench for axis_pkt_checker: per-packet expectations are queued at send time
// and retired by a monitor when pkt_cnt_o advances.
module tb_axis_pkt_checker;

  localparam int unsigned BUDGET = 1000;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [15:0] exp_len_i = '0;
  logic [7:0]  start_val_i = '0;
  logic        bp_en_i = 1'b0;
  logic        clr_i = 1'b0;
  logic [31:0] pkt_cnt_o;
  logic [31:0] err_cnt_o;
  logic [2:0]  err_flags_o;
  logic        err_o;
  logic        busy_o;

  axis_pkt_checker #(
    .DATA_WIDTH(8),
    .LEN_WIDTH (16),
    .CNT_WIDTH (32),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .exp_len_i    (exp_len_i),
    .start_val_i  (start_val_i),
    .bp_en_i      (bp_en_i),
    .clr_i        (clr_i),
    .pkt_cnt_o    (pkt_cnt_o),
    .err_cnt_o    (err_cnt_o),
    .err_flags_o  (err_flags_o),
    .err_o        (err_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       bad;
    logic [2:0] flags;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  logic [31:0] exp_pkt = '0;
  logic [31:0] exp_err = '0;
  logic [2:0]  exp_flags = '0;
  int          err_pulses = 0;
  logic        saw_low = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t it;
    logic popped;
    popped = 1'b0;
    it = '0;
    if (mon_en) begin
      if (pkt_cnt_o !== exp_pkt) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: pkt_cnt_o=%0d but no packet outstanding (model %0d)", pkt_cnt_o, exp_pkt);
          exp_pkt = pkt_cnt_o;
        end else begin
          it = sb_q.pop_front();
          popped = 1'b1;
          exp_pkt = exp_pkt + 1;
          if (it.bad) exp_err = exp_err + 1;
          exp_flags = exp_flags | it.flags;
          n_checks++;
          if (pkt_cnt_o !== exp_pkt) begin
            n_fail++;
            $display("FAIL sb_pkt_cnt: got %0d expected %0d", pkt_cnt_o, exp_pkt);
          end
          n_checks++;
          if (err_cnt_o !== exp_err) begin
            n_fail++;
            $display("FAIL sb_err_cnt: got %0d expected %0d", err_cnt_o, exp_err);
          end
          n_checks++;
          if (err_flags_o !== exp_flags) begin
            n_fail++;
            $display("FAIL sb_flags: got %b expected %b", err_flags_o, exp_flags);
          end
        end
      end
      n_checks++;
      if (err_o !== (popped & it.bad)) begin
        n_fail++;
        $display("FAIL sb_err_o: got %b expected %b", err_o, popped & it.bad);
      end
      if (err_o === 1'b1) err_pulses++;
    end
  end

  task automatic model_reset();
    sb_q.delete();
    exp_pkt    = '0;
    exp_err    = '0;
    exp_flags  = '0;
    err_pulses = 0;
  endtask

  task automatic clear_counters();
    mon_en = 1'b0;
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
    model_reset();
    mon_en = 1'b1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int unsigned waited;
    logic acc;
    waited = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    do begin
      acc = s_axis_tready;
      if (!acc) saw_low = 1'b1;
      @(posedge clk); #1;
      waited++;
    end while (!acc && waited < BUDGET);
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_timeout: tready=%b after %0d cycles, required 1", s_axis_tready, waited);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [7:0] start, input logic [15:0] len,
                          input int bad_idx, input logic [7:0] bad_val);
    logic [7:0] d[64];
    exp_t it;
    logic long_seen;
    logic supp;
    int   l;
    l = int'(len);
    it = '0;
    long_seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      d[k] = (k == bad_idx) ? bad_val : start + 8'(k);
      supp = long_seen || (l != 0 && k == l - 1 && k != n - 1);
      if (l != 0 && k == l - 1 && k != n - 1) begin
        it.flags[2] = 1'b1;
        long_seen = 1'b1;
      end
      if (!supp && d[k] != start + 8'(k)) it.flags[0] = 1'b1;
    end
    if (l != 0 && n - 1 < l - 1) it.flags[1] = 1'b1;
    it.bad = |it.flags;
    exp_len_i   = len;
    start_val_i = start;
    sb_q.push_back(it);
    for (int k = 0; k < n; k++) begin
      send_beat(d[k], k == n - 1);
    end
  endtask

  task automatic settle_and_check(input string name, input logic [31:0] pkt,
                                  input logic [31:0] errs, input logic [2:0] flags,
                                  input int pulses);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (pkt_cnt_o !== pkt) begin
      n_fail++;
      $display("FAIL %s_pkt_cnt: got %0d expected %0d", name, pkt_cnt_o, pkt);
    end
    n_checks++;
    if (err_cnt_o !== errs) begin
      n_fail++;
      $display("FAIL %s_err_cnt: got %0d expected %0d", name, err_cnt_o, errs);
    end
    n_checks++;
    if (err_flags_o !== flags) begin
      n_fail++;
      $display("FAIL %s_flags: got %b expected %b", name, err_flags_o, flags);
    end
    n_checks++;
    if (err_pulses != pulses) begin
      n_fail++;
      $display("FAIL %s_err_pulses: got %0d expected %0d", name, err_pulses, pulses);
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_sb_pending: got %0d packets outstanding expected 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({s_axis_tready, busy_o, err_o, err_flags_o} !== 6'b0 || pkt_cnt_o !== '0 || err_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL reset_state: tready=%b busy=%b err=%b flags=%b pkt=%0d errc=%0d expected all 0",
               s_axis_tready, busy_o, err_o, err_flags_o, pkt_cnt_o, err_cnt_o);
    end
    rstn_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_tready: got %b expected 1", s_axis_tready);
    end
    model_reset();
    mon_en = 1'b1;
  endtask

  task automatic test_data_mismatch();
    clear_counters();
    send_pkt(4, 8'h10, 16'd4, 2, 8'h13);
    settle_and_check("mismatch", 32'd1, 32'd1, 3'b001, 1);
  endtask

  task automatic test_good_packets();
    clear_counters();
    for (int p = 0; p < 10; p++) begin
      send_pkt(4, 8'h10, 16'd4, -1, 8'h00);
    end
    settle_and_check("good", 32'd10, 32'd0, 3'b000, 0);
  endtask

  task automatic test_short_packet();
    clear_counters();
    send_pkt(2, 8'h10, 16'd4, -1, 8'h00);
    settle_and_check("short", 32'd1, 32'd1, 3'b010, 1);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL short_busy: got %b expected 0", busy_o);
    end
  endtask

  task automatic test_long_packet();
    clear_counters();
    send_pkt(6, 8'h10, 16'd4, -1, 8'h00);
    settle_and_check("long", 32'd1, 32'd1, 3'b100, 1);
  endtask

  task automatic test_backpressure();
    clear_counters();
    bp_en_i = 1'b1;
    saw_low = 1'b0;
    for (int p = 0; p < 100; p++) begin
      send_pkt(16, 8'hFE, 16'd16, -1, 8'h00);
    end
    bp_en_i = 1'b0;
    settle_and_check("bp", 32'd100, 32'd0, 3'b000, 0);
    n_checks++;
`ifdef AXIS_CHK_BACKPRESSURE_EN
    if (saw_low !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_tready_low: saw_low=%b expected 1", saw_low);
    end
`else
    if (saw_low !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ignored: saw_low=%b expected 0", saw_low);
    end
`endif
  endtask

  task automatic test_reset_and_clear();
    clear_counters();
    mon_en = 1'b0;
    exp_len_i   = 16'd4;
    start_val_i = 8'h10;
    send_beat(8'h10, 1'b0);
    send_beat(8'h11, 1'b0);
    s_axis_tdata  = 8'h12;
    s_axis_tvalid = 1'b1;
    rstn_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    rstn_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (pkt_cnt_o !== '0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midpkt_reset: pkt=%0d busy=%b expected 0 0", pkt_cnt_o, busy_o);
    end
    model_reset();
    mon_en = 1'b1;
    send_pkt(4, 8'h10, 16'd4, -1, 8'h00);
    settle_and_check("after_reset", 32'd1, 32'd0, 3'b000, 0);
    mon_en = 1'b0;
    send_beat(8'h10, 1'b0);
    send_beat(8'h11, 1'b0);
    send_beat(8'h12, 1'b0);
    clr_i = 1'b1;
    send_beat(8'h13, 1'b1);
    clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (pkt_cnt_o !== '0 || err_cnt_o !== '0 || err_flags_o !== 3'b000) begin
      n_fail++;
      $display("FAIL clr_on_tlast: pkt=%0d errc=%0d flags=%b expected 0 0 000",
               pkt_cnt_o, err_cnt_o, err_flags_o);
    end
    model_reset();
    mon_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_data_mismatch();
    test_good_packets();
    test_short_packet();
    test_long_packet();
    test_backpressure();
    test_reset_and_clear();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
